spe_ingress_buffer: RTL and testbench

//  Clocked ingress stage of the SPE, directly upstream of the SPE functional block.
//  - Accepts 33-bit NoC packets from the router port over a valid/ready handshake.
//  - Checks the destination address; keeps packets for this PE or for broadcast, discards all others.
//  - Stores kept packets as {opcode, data} in a small FIFO and presents them downstream over valid/ready.
//  - Counts discarded packets for debug.

---
 rtl/spe_ingress_buffer.sv | 121 ++++++++++++
 tb/tb_spe_ingress_buffer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spe_ingress_buffer.sv
// SPE ingress stage: filters NoC packets by destination address and queues
// kept {opcode, data} entries in a small FIFO for the SPE functional block.

module spe_ingress_entry #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
endmodule

module spe_ingress_buffer #(
  parameter int         PKT_W        = 33,
  parameter int         ADDR_START   = 32,
  parameter int         ADDR_END     = 29,
  parameter int         OPCODE_START = 28,
  parameter int         OPCODE_END   = 25,
  parameter int         DATA_START   = 24,
  parameter int         DATA_END     = 0,
  parameter int         PE_ID        = 0,
  parameter logic [3:0] BCAST_ADDR   = 4'hF,
  parameter int         DEPTH        = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PKT_W-1:0]                  in_packet,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OPCODE_START-OPCODE_END:0]  out_opcode,
  output logic [DATA_START-DATA_END:0]      out_data,
  output logic [$clog2(DEPTH):0]            occupancy,
  output logic                              drop_pulse,
  output logic [7:0]                        drop_count
);
  localparam int AW = ADDR_START - ADDR_END + 1;
  localparam int OW = OPCODE_START - OPCODE_END + 1;
  localparam int DW = DATA_START - DATA_END + 1;
  localparam int EW = OW + DW;
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef struct packed {
    logic [OW-1:0] opcode;
    logic [DW-1:0] data;
  } entry_t;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [AW-1:0] pkt_addr;
  entry_t        pkt_ent, head;
  logic          accept, keep, push, pop, full_nxt, empty_nxt;

  logic [DEPTH-1:0]         ent_we;
  logic [DEPTH-1:0][EW-1:0] ent_q;

  assign pkt_addr = in_packet[ADDR_START:ADDR_END];
  assign pkt_ent  = '{opcode: in_packet[OPCODE_START:OPCODE_END],
                      data:   in_packet[DATA_START:DATA_END]};

  assign keep   = (pkt_addr == AW'(PE_ID)) || (pkt_addr == AW'(BCAST_ADDR));
  assign accept = in_valid && in_ready;
  assign push   = accept && keep;
  assign pop    = out_valid && out_ready;

  assign wr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
  assign rd_nxt = pop  ? rd_ptr + PW'(1) : rd_ptr;

  // Flags are computed on the next pointers so the registered handshakes
  // track occupancy exactly, one edge after each push/pop.
  assign full_nxt  = (wr_nxt[IW] != rd_nxt[IW]) && (wr_nxt[IW-1:0] == rd_nxt[IW-1:0]);
  assign empty_nxt = (wr_nxt == rd_nxt);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      in_ready  <= !full_nxt;
      out_valid <= !empty_nxt;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= accept && !keep;
      if (accept && !keep && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i] = push && (wr_ptr[IW-1:0] == IW'(i));
    spe_ingress_entry #(.W(EW)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ent_we[i]),
      .d     (pkt_ent),
      .q     (ent_q[i])
    );
  end

  // Head is read straight from storage; it cannot change while held because
  // the write slot never aliases the head unless the FIFO is empty.
  assign head       = ent_q[rd_ptr[IW-1:0]];
  assign out_opcode = head.opcode;
  assign out_data   = head.data;
  assign occupancy  = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_spe_ingress_buffer.sv
// Randomized + directed bench for spe_ingress_buffer against a queue model.

module tb_spe_ingress_buffer;
  localparam int DEPTH = 4;
  localparam int PE    = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [32:0] in_packet = '0;
  logic        in_ready, out_valid, drop_pulse;
  logic [3:0]  out_opcode;
  logic [24:0] out_data;
  logic [2:0]  occupancy;
  logic [7:0]  drop_count;

  spe_ingress_buffer #(.PE_ID(PE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_packet  (in_packet),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] mk(input logic [3:0] a, input logic [3:0] op, input logic [24:0] d);
    return {a, op, d};
  endfunction

  // Reference: plain queue of kept {opcode,data}, flags derived from its size.
  logic [28:0] q[$];
  bit m_in_ready = 1'b0, m_out_valid = 1'b0, m_drop_pulse = 1'b0;
  int m_drop_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_in_ready   = 1'b0;
      m_out_valid  = 1'b0;
      m_drop_pulse = 1'b0;
      m_drop_cnt   = 0;
    end else begin
      bit acc, pp;
      acc = in_valid && m_in_ready;
      pp  = m_out_valid && out_ready;
      if (pp) void'(q.pop_front());
      m_drop_pulse = 1'b0;
      if (acc) begin
        if (in_packet[32:29] == 4'(PE) || in_packet[32:29] == 4'hF)
          q.push_back(in_packet[28:0]);
        else begin
          m_drop_pulse = 1'b1;
          if (m_drop_cnt < 255) m_drop_cnt++;
        end
      end
      m_in_ready  = (q.size() != DEPTH);
      m_out_valid = (q.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   32'(in_ready),   32'(m_in_ready));
      chk("out_valid",  32'(out_valid),  32'(m_out_valid));
      chk("occupancy",  32'(occupancy),  32'(q.size()));
      chk("drop_pulse", 32'(drop_pulse), 32'(m_drop_pulse));
      chk("drop_count", 32'(drop_count), 32'(m_drop_cnt));
      if (m_out_valid && q.size() != 0) begin
        chk("out_opcode", 32'(out_opcode), 32'(q[0][28:25]));
        chk("out_data",   32'(out_data),   32'(q[0][24:0]));
      end
    end
  end

  // Holds the packet until the handshake completes; returns 1 ns after the
  // accepting edge.
  task automatic send(input logic [32:0] p);
    bit acc;
    int n;
    in_valid  = 1'b1;
    in_packet = p;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state
    cyc(3);
    chk("rst_out_valid",  32'(out_valid),  0);
    chk("rst_in_ready",   32'(in_ready),   0);
    chk("rst_occupancy",  32'(occupancy),  0);
    chk("rst_drop_pulse", 32'(drop_pulse), 0);
    chk("rst_drop_count", 32'(drop_count), 0);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    cyc(1);
    chk("rdy_after_rst", 32'(in_ready), 1);

    // single kept packet, next-cycle visibility
    out_ready = 1'b1;
    send(mk(4'd3, 4'd2, 25'h0ABCD));
    chk("lat_valid",  32'(out_valid),  1);
    chk("lat_opcode", 32'(out_opcode), 2);
    chk("lat_data",   32'(out_data),   32'h0ABCD);
    cyc(1);
    chk("lat_drain", 32'(occupancy), 0);

    // drop then broadcast
    send(mk(4'd5, 4'd1, 25'h11111));
    chk("drop_pulse1", 32'(drop_pulse), 1);
    chk("drop_count1", 32'(drop_count), 1);
    send(mk(4'hF, 4'd7, 25'h1F00F));
    chk("drop_pulse0", 32'(drop_pulse), 0);
    chk("bcast_valid", 32'(out_valid),  1);
    chk("bcast_data",  32'(out_data),   32'h1F00F);
    cyc(3);

    // fill with out_ready low, fifth packet stalls
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(mk(4'd3, 4'(i), 25'(i * 25'h101)));
    chk("full_occ",   32'(occupancy), 4);
    chk("full_ready", 32'(in_ready),  0);
    in_valid  = 1'b1;
    in_packet = mk(4'd3, 4'd5, 25'h505);
    cyc(2);
    chk("stall_occ", 32'(occupancy), 4);
    out_ready = 1'b1;
    send(mk(4'd3, 4'd5, 25'h505));
    cyc(8);
    chk("drain5_occ", 32'(occupancy), 0);

    // full FIFO, streaming 10 packets with both sides active
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(mk(4'hF, 4'(i), 25'($urandom)));
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(mk(4'd3, 4'(i + 8), 25'($urandom)));
    cyc(8);
    chk("stream_occ", 32'(occupancy), 0);

    // drop counter saturation
    for (int i = 0; i < 260; i++) send(mk(4'd5 + 4'(i % 8), 4'd0, 25'($urandom)));
    cyc(1);
    chk("sat_count", 32'(drop_count), 255);
    chk("sat_occ",   32'(occupancy),  0);

    // reset mid-stream with two entries held
    out_ready = 1'b0;
    send(mk(4'd3, 4'd9, 25'h999));
    send(mk(4'hF, 4'hA, 25'hAAA));
    chk("pre_rst_occ", 32'(occupancy), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid),  0);
    chk("mid_rst_occ",   32'(occupancy),  0);
    chk("mid_rst_drop",  32'(drop_count), 0);
    chk("mid_rst_ready", 32'(in_ready),   0);
    cyc(1);
    #1 rst_n = 1'b1;
    cyc(1);
    chk("post_rst_ready", 32'(in_ready),  1);
    chk("post_rst_occ",   32'(occupancy), 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] a;
      case ($urandom_range(0, 3))
        0:       a = 4'd3;
        1:       a = 4'hF;
        default: a = 4'($urandom);
      endcase
      in_valid  = ($urandom_range(0, 2) != 0);
      in_packet = mk(a, 4'($urandom), 25'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(10);
    chk("final_occ", 32'(occupancy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
